// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Oversampled UART receiver. The asynchronous rx line is synchronised,
//   each bit is decided by a 3-sample majority vote around mid-bit, and a
//   completed frame is reported as a one-clk valid strobe plus a held
//   command word that clears itself after HOLD_TICKS idle oversample ticks.
//   Optional feature macro: UART_RX_PARITY_EN (adds a parity bit per frame,
//   the PARITY state and parameter PARITY_ODD; otherwise parity_err is 0).
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last good word, updates together with valid
//   valid      out  one-clk pulse per good frame
//   hold_data  out  held command word, 0 once expired
//   frame_err  out  one-clk pulse when the stop bit is sampled low
//   parity_err out  one-clk pulse on parity mismatch
//   busy       out  high whenever the receiver is not idle
module uart_rx_core #(
  parameter int unsigned CLK_DIV    = 650,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned HOLD_TICKS = 640
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic [DATA_BITS-1:0] hold_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW        = $clog2(OVERSAMPLE);
  localparam int unsigned BW        = $clog2(DATA_BITS + 1);
  localparam int unsigned HW        = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;
  localparam int unsigned PH_LO     = OVERSAMPLE / 2 - 1;
  localparam int unsigned PH_MID    = OVERSAMPLE / 2;
  localparam int unsigned PH_DEC    = OVERSAMPLE / 2 + 1;
  localparam int unsigned PH_LAST   = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_next;

  logic                 rx_meta, rxs;
  logic [TW-1:0]        tcnt;
  logic                 tick;
  logic [PW-1:0]        ph, ph_inc;
  logic                 s_lo, s_mid, vote;
  logic                 start_det, dec, wrap;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [HW-1:0]        hold_cnt;
  logic                 shift_en, good, ferr;
`ifdef UART_RX_PARITY_EN
  logic                 par_set, par_bad, perr;
`endif

  // Two-flop synchroniser; idles high so reset does not look like a start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ph_inc is the phase a tick moves into; all sample points are keyed on it
  // so that the decision lands OVERSAMPLE/2+1 ticks into each bit.
  assign tick      = (tcnt == TW'(CLK_DIV - 1));
  assign ph_inc    = (ph == PW'(PH_LAST)) ? '0 : PW'(ph + 1'b1);
  assign start_det = (state == S_IDLE) && !rxs;
  assign dec       = tick && (ph_inc == PW'(PH_DEC));
  assign wrap      = tick && (ph_inc == '0);
  assign vote      = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  // Tick and phase counters, realigned on start detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt  <= '0;
      ph    <= '0;
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (start_det) begin
      tcnt <= '0;
      ph   <= '0;
    end else begin
      tcnt <= tick ? '0 : TW'(tcnt + 1'b1);
      if (tick) begin
        ph <= ph_inc;
        if (ph_inc == PW'(PH_LO))  s_lo  <= rxs;
        if (ph_inc == PW'(PH_MID)) s_mid <= rxs;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // FSM next-state and event decode.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    good       = 1'b0;
    ferr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set    = 1'b0;
    perr       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rxs) state_next = S_START;
      end
      S_START: begin
        if (dec && vote) state_next = S_IDLE;
        else if (wrap)   state_next = S_DATA;
      end
      S_DATA: begin
        if (dec) shift_en = 1'b1;
        if (wrap && (bcnt == BW'(DATA_BITS))) begin
`ifdef UART_RX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (dec)  par_set    = 1'b1;
        if (wrap) state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (dec) begin
          if (vote) begin
`ifdef UART_RX_PARITY_EN
            if (par_bad) perr = 1'b1;
            else         good = 1'b1;
`else
            good = 1'b1;
`endif
            state_next = S_IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      // Stay here until the line is seen high, so a held break is one error.
      S_BREAK: begin
        if (dec && rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Shift register (LSB first) and bit counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (start_det) begin
      bcnt <= '0;
    end else if (shift_en) begin
      shreg <= {vote, shreg[DATA_BITS-1:1]};
      bcnt  <= BW'(bcnt + 1'b1);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Latch parity mismatch; reported only once the stop bit is good.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr;
      if (start_det)    par_bad <= 1'b0;
      else if (par_set) par_bad <= vote ^ (^shreg) ^ 1'(PARITY_ODD);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // Frame result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= good;
      frame_err <= ferr;
      busy      <= (state_next != S_IDLE);
      if (good) data <= shreg;
    end
  end

  // Held command word; a new good frame takes priority over expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data <= '0;
      hold_cnt  <= '0;
    end else if (good) begin
      hold_data <= shreg;
      hold_cnt  <= '0;
    end else if (tick && (hold_data != '0) && (HOLD_TICKS != 0)) begin
      if (hold_cnt == HW'(HOLD_LAST)) begin
        hold_data <= '0;
        hold_cnt  <= '0;
      end else begin
        hold_cnt <= HW'(hold_cnt + 1'b1);
      end
    end
  end

endmodule
